// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream instruction channel plus
// downstream immediate channel. The master side is the environment; the block uses slave.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instruction;
  logic [2:0]       i_sel;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_dataout;
  logic [2:0]       o_sel;
  logic             o_illegal;
  logic [CNT_W-1:0] o_illegal_cnt;

  modport master (
    output i_valid, i_instruction, i_sel, i_ready,
    input  o_ready, o_valid, o_dataout, o_sel, o_illegal, o_illegal_cnt
  );

  modport slave (
    input  i_valid, i_instruction, i_sel, i_ready,
    output o_ready, o_valid, o_dataout, o_sel, o_illegal, o_illegal_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate extractor behind a 2-entry skid buffer.
// Define IMM_GEN_ZIMM_EN to enable the CSR zimm format (select 6).
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int CNT_W       = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  imm_gen_pipe_if.slave bus
);

`ifdef IMM_GEN_ZIMM_EN
  localparam bit ZIMM_EN = 1'b1;
`else
  localparam bit ZIMM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_r, state_s;
  logic             ready_r, valid_r;
  logic [XLEN-1:0]  out_data_r, skid_data_r, imm_s;
  logic [2:0]       out_sel_r, skid_sel_r, fmt_s, req_sel_s, auto_sel_s;
  logic             out_ill_r, skid_ill_r, ill_s, auto_ill_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      ins_s, raw_s;
  logic             sign_s;
  logic             accept_s, drain_s, load_out_s, load_skid_s, skid_to_out_s;

  assign ins_s    = bus.i_instruction;
  assign accept_s = bus.i_valid && ready_r;
  assign drain_s  = valid_r && bus.i_ready;

  // Opcode auto-decode and choice of the applied format
  always_comb begin
    auto_sel_s = 3'd7;
    auto_ill_s = 1'b0;
    case (ins_s[6:0])
      7'b0010011: auto_sel_s = (ins_s[13:12] == 2'b01) ? 3'd5 : 3'd0;
      7'b0000011, 7'b1100111: auto_sel_s = 3'd0;
      7'b0100011: auto_sel_s = 3'd1;
      7'b1100011: auto_sel_s = 3'd2;
      7'b0110111, 7'b0010111: auto_sel_s = 3'd3;
      7'b1101111: auto_sel_s = 3'd4;
      7'b1110011: auto_sel_s = (ZIMM_EN && ins_s[14]) ? 3'd6 : 3'd0;
      7'b0110011, 7'b0001111: auto_sel_s = 3'd7;
      default: begin
        auto_sel_s = 3'd7;
        auto_ill_s = 1'b1;
      end
    endcase
    if (AUTO_DECODE != 0) begin
      req_sel_s = auto_sel_s;
      ill_s     = auto_ill_s;
    end else begin
      req_sel_s = bus.i_sel;
      ill_s     = 1'b0;
    end
    // Without the zimm feature select 6 collapses onto NONE, including o_sel.
    if (req_sel_s == 3'd6 && !ZIMM_EN) begin
      fmt_s = 3'd7;
    end else begin
      fmt_s = req_sel_s;
    end
  end

  // Immediate assembly: low 32 bits per format, upper bits filled with the sign
  always_comb begin
    raw_s  = 32'd0;
    sign_s = 1'b0;
    case (fmt_s)
      3'd0: begin raw_s = {{20{ins_s[31]}}, ins_s[31:20]}; sign_s = ins_s[31]; end
      3'd1: begin raw_s = {{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]}; sign_s = ins_s[31]; end
      3'd2: begin
        raw_s  = {{19{ins_s[31]}}, ins_s[31], ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0};
        sign_s = ins_s[31];
      end
      3'd3: begin raw_s = {ins_s[31:12], 12'd0}; sign_s = ins_s[31]; end
      3'd4: begin
        raw_s  = {{11{ins_s[31]}}, ins_s[31], ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0};
        sign_s = ins_s[31];
      end
      3'd5: raw_s = (XLEN == 64) ? {26'd0, ins_s[25:20]} : {27'd0, ins_s[24:20]};
      3'd6: raw_s = {27'd0, ins_s[19:15]};
      default: raw_s = 32'd0;
    endcase
    imm_s       = {XLEN{sign_s}};
    imm_s[31:0] = raw_s;
  end

  // Skid-buffer next state and register load strobes
  always_comb begin
    state_s       = state_r;
    load_out_s    = 1'b0;
    load_skid_s   = 1'b0;
    skid_to_out_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_s    = ONE;
          load_out_s = 1'b1;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && drain_s) begin
          load_out_s = 1'b1;
        end else if (accept_s) begin
          state_s     = FULL;
          load_skid_s = 1'b1;
        end else if (drain_s) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      FULL: begin
        if (drain_s) begin
          state_s       = ONE;
          skid_to_out_s = 1'b1;
        end else begin
          state_s = FULL;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // State plus registered ready/valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= EMPTY;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s != FULL);
      valid_r <= (state_s != EMPTY);
    end
  end

  // Output register: fresh entry or promoted skid entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_data_r <= '0;
      out_sel_r  <= 3'd7;
      out_ill_r  <= 1'b0;
    end else if (load_out_s) begin
      out_data_r <= imm_s;
      out_sel_r  <= fmt_s;
      out_ill_r  <= ill_s;
    end else if (skid_to_out_s) begin
      out_data_r <= skid_data_r;
      out_sel_r  <= skid_sel_r;
      out_ill_r  <= skid_ill_r;
    end else begin
      out_data_r <= out_data_r;
      out_sel_r  <= out_sel_r;
      out_ill_r  <= out_ill_r;
    end
  end

  // Skid register captures the entry accepted while the output is stalled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      skid_data_r <= '0;
      skid_sel_r  <= 3'd7;
      skid_ill_r  <= 1'b0;
    end else if (load_skid_s) begin
      skid_data_r <= imm_s;
      skid_sel_r  <= fmt_s;
      skid_ill_r  <= ill_s;
    end else begin
      skid_data_r <= skid_data_r;
      skid_sel_r  <= skid_sel_r;
      skid_ill_r  <= skid_ill_r;
    end
  end

  // Saturating count of accepted illegal instructions
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= '0;
    end else if (accept_s && ill_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.o_ready       = ready_r;
  assign bus.o_valid       = valid_r;
  assign bus.o_dataout     = out_data_r;
  assign bus.o_sel         = out_sel_r;
  assign bus.o_illegal     = out_ill_r;
  assign bus.o_illegal_cnt = cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: explicit-select RV32 instance (a) and auto-decode RV64
// instance with a 2-bit illegal counter (b), sharing one clock and reset.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_t [5];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .CNT_W(8)) ia ();
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(2)) ib ();

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .CNT_W(8)) u_a (.i_clk(clk), .i_rst(rst), .bus(ia));
  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .CNT_W(2)) u_b (.i_clk(clk), .i_rst(rst), .bus(ib));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_t[0] = 32'h0000_0123; exp_t[1] = 32'h0000_0122; exp_t[2] = 32'h0000_0122;
    exp_t[3] = 32'h1235_3000; exp_t[4] = 32'h0005_3922;
    ia.i_valid = 1'b0; ia.i_instruction = 32'd0; ia.i_sel = 3'd0; ia.i_ready = 1'b1;
    ib.i_valid = 1'b0; ib.i_instruction = 32'd0; ib.i_sel = 3'd0; ib.i_ready = 1'b1;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    // reset state
    check("rst_a_valid", 64'(ia.o_valid), 64'd0);
    check("rst_a_ready", 64'(ia.o_ready), 64'd1);
    check("rst_a_data",  64'(ia.o_dataout), 64'd0);
    check("rst_a_sel",   64'(ia.o_sel), 64'd7);
    check("rst_a_ill",   64'(ia.o_illegal), 64'd0);
    check("rst_a_cnt",   64'(ia.o_illegal_cnt), 64'd0);
    check("rst_b_sel",   64'(ib.o_sel), 64'd7);

    // explicit formats 0..4, one per cycle
    ia.i_valid = 1'b1; ia.i_instruction = 32'h1235_3112;
    for (int s = 0; s < 5; s++) begin
      ia.i_sel = 3'(s);
      cyc();
      check($sformatf("fmt%0d_valid", s), 64'(ia.o_valid), 64'd1);
      check($sformatf("fmt%0d_data", s), 64'(ia.o_dataout), 64'(exp_t[s]));
      check($sformatf("fmt%0d_sel", s), 64'(ia.o_sel), 64'(s));
      check($sformatf("fmt%0d_ready", s), 64'(ia.o_ready), 64'd1);
    end
    ia.i_instruction = 32'hFFF0_0093; ia.i_sel = 3'd0;
    cyc();
    check("a_neg_i", 64'(ia.o_dataout), 64'h0000_0000_FFFF_FFFF);
    ia.i_instruction = 32'h0210_9093; ia.i_sel = 3'd5;
    cyc();
    check("a_shamt32", 64'(ia.o_dataout), 64'd1);
    ia.i_instruction = 32'h3401_D073; ia.i_sel = 3'd6;
    cyc();
`ifdef IMM_GEN_ZIMM_EN
    check("a_sel6_sel", 64'(ia.o_sel), 64'd6);
    check("a_sel6_data", 64'(ia.o_dataout), 64'd3);
`else
    check("a_sel6_sel", 64'(ia.o_sel), 64'd7);
    check("a_sel6_data", 64'(ia.o_dataout), 64'd0);
`endif
    ia.i_sel = 3'd7;
    cyc();
    check("a_none_data", 64'(ia.o_dataout), 64'd0);
    check("a_none_ill", 64'(ia.o_illegal), 64'd0);
    ia.i_valid = 1'b0;
    cyc();
    check("a_drained", 64'(ia.o_valid), 64'd0);

    // auto-decode on the RV64 instance
    ib.i_valid = 1'b1; ib.i_instruction = 32'hFFF0_0093;
    cyc();
    check("b_neg_sel", 64'(ib.o_sel), 64'd0);
    check("b_neg_data", ib.o_dataout, 64'hFFFF_FFFF_FFFF_FFFF);
    ib.i_instruction = 32'h0210_9093;
    cyc();
    check("b_shamt_sel", 64'(ib.o_sel), 64'd5);
    check("b_shamt64", ib.o_dataout, 64'd33);
    ib.i_instruction = 32'h3401_D073;
    cyc();
`ifdef IMM_GEN_ZIMM_EN
    check("b_csr_sel", 64'(ib.o_sel), 64'd6);
    check("b_csr_data", ib.o_dataout, 64'd3);
`else
    check("b_csr_sel", 64'(ib.o_sel), 64'd0);
    check("b_csr_data", ib.o_dataout, 64'h340);
`endif
    ib.i_instruction = 32'h0000_0033;
    cyc();
    check("b_rtype_sel", 64'(ib.o_sel), 64'd7);
    check("b_rtype_ill", 64'(ib.o_illegal), 64'd0);
    check("b_rtype_cnt", 64'(ib.o_illegal_cnt), 64'd0);
    ib.i_instruction = 32'h1235_3112;
    cyc();
    check("b_ill_flag", 64'(ib.o_illegal), 64'd1);
    check("b_ill_data", ib.o_dataout, 64'd0);
    check("b_ill_sel", 64'(ib.o_sel), 64'd7);
    check("b_ill_cnt1", 64'(ib.o_illegal_cnt), 64'd1);
    cyc();
    check("b_ill_cnt2", 64'(ib.o_illegal_cnt), 64'd2);
    cyc(); cyc(); cyc();
    check("b_ill_sat", 64'(ib.o_illegal_cnt), 64'd3);
    ib.i_valid = 1'b0;
    cyc();

    // backpressure on a: A, B accepted, C held off
    ia.i_ready = 1'b0; ia.i_valid = 1'b1; ia.i_sel = 3'd0; ia.i_instruction = 32'h0010_0093;
    cyc();
    check("bp_one_data", 64'(ia.o_dataout), 64'd1);
    check("bp_one_ready", 64'(ia.o_ready), 64'd1);
    ia.i_instruction = 32'h0020_0093;
    cyc();
    check("bp_full_ready", 64'(ia.o_ready), 64'd0);
    check("bp_full_data", 64'(ia.o_dataout), 64'd1);
    ia.i_instruction = 32'h0030_0093;
    cyc();
    check("bp_hold_ready", 64'(ia.o_ready), 64'd0);
    check("bp_hold_data", 64'(ia.o_dataout), 64'd1);
    ia.i_ready = 1'b1;
    cyc();
    check("bp_b_data", 64'(ia.o_dataout), 64'd2);
    check("bp_b_ready", 64'(ia.o_ready), 64'd1);
    cyc();
    check("bp_c_data", 64'(ia.o_dataout), 64'd3);
    check("bp_c_valid", 64'(ia.o_valid), 64'd1);
    ia.i_valid = 1'b0;
    cyc();
    check("bp_empty", 64'(ia.o_valid), 64'd0);

    // reset with b FULL, handshake offered during the reset cycle
    ib.i_ready = 1'b0; ib.i_valid = 1'b1; ib.i_instruction = 32'h0010_0093;
    cyc();
    ib.i_instruction = 32'h0020_0093;
    cyc();
    check("rf_full", 64'(ib.o_ready), 64'd0);
    rst = 1'b1; ib.i_instruction = 32'h0030_0093; ib.i_ready = 1'b1;
    cyc();
    rst = 1'b0; ib.i_valid = 1'b0;
    check("rf_valid", 64'(ib.o_valid), 64'd0);
    check("rf_ready", 64'(ib.o_ready), 64'd1);
    check("rf_cnt", 64'(ib.o_illegal_cnt), 64'd0);
    check("rf_sel", 64'(ib.o_sel), 64'd7);
    cyc();
    check("rf_no_b", 64'(ib.o_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised successor to the combinational immediate generator; sits between fetch/decode and the execute operand mux.
- Accepts 32-bit RV32I/RV64I instructions over a valid/ready handshake and extracts the sign- or zero-extended immediate to XLEN.
- The format comes either from an explicit select or from opcode auto-decode.
- A 2-entry skid buffer gives registered ready and full throughput.
- A saturating counter tracks illegal opcodes.

Parameters:
- XLEN, 32, output width; legal values are 32 or 64.
- AUTO_DECODE, 0, 0 = format taken from i_sel; 1 = i_sel ignored, format derived from the opcode.
- CNT_W, 8, width of the illegal-opcode counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input instruction valid.
- o_ready  out  1  block can accept; driven from a register.
- i_instruction  in  32  instruction word.
- i_sel  in  3  format select; used only when AUTO_DECODE=0.
- o_valid  out  1  output valid.
- i_ready  in  1  downstream accepts.
- o_dataout  out  XLEN  extended immediate.
- o_sel  out  3  format actually applied.
- o_illegal  out  1  auto-decode found an unknown opcode.
- o_illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Select encoding:
  - 0=I: sext(ins[31:20]).
  - 1=S: sext({ins[31:25],ins[11:7]}).
  - 2=B: sext({ins[31],ins[7],ins[30:25],ins[11:8],0}).
  - 3=U: sext({ins[31:12],12'b0}).
  - 4=J: sext({ins[31],ins[19:12],ins[20],ins[30:21],0}).
  - 5=SHAMT: zero-extended ins[24:20] when XLEN=32, ins[25:20] when XLEN=64.
  - 6=Z: see Optional Feature.
  - 7=NONE: output 0.
- All sign extension uses ins[31] up to XLEN.
- Auto-decode (opcode = ins[6:0]):
  - 0010011 -> SHAMT if funct3 is 001 or 101, else I.
  - 0000011 and 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111 and 0010111 -> U.
  - 1101111 -> J.
  - 1110011 -> I.
  - 0110011 -> NONE, not illegal.
  - 0001111 -> NONE.
  - Any other opcode -> NONE with o_illegal=1.
- o_illegal is always 0 when AUTO_DECODE=0.
- Handshake:
  - A transfer happens on a cycle where valid && ready on a rising edge.
  - Latency is 1 cycle: an instruction accepted at edge N is presented with o_valid=1 after edge N.
  - Output fields are held stable while o_valid && !i_ready.
- Buffer state machine:
  - EMPTY: o_valid=0, o_ready=1.
    - Accept -> ONE.
  - ONE: o_valid=1, o_ready=1.
    - Accept only -> FULL; the new entry goes to the skid register.
    - Drain only -> EMPTY.
    - Accept and drain together -> stay in ONE; the new entry loads the output register.
  - FULL: o_valid=1, o_ready=0.
    - Drain -> ONE; the skid entry moves to the output register.
    - Input is ignored in FULL.
- o_ready is 1 iff state != FULL; it is a registered value and has no combinational path from i_ready.
- Counter:
  - Increments by 1 on each accepted instruction that auto-decodes as illegal.
  - Saturates at 2^CNT_W-1, with no wrap.
- Reset:
  - Next edge with i_rst=1 -> EMPTY.
  - After reset: o_valid=0, o_ready=1, o_dataout=0, o_sel=7, o_illegal=0, o_illegal_cnt=0.
  - Buffered entries are discarded and not presented after reset.
  - A handshake in the reset cycle is dropped.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined:
  - sel 6 = CSR zimm: zero-extended ins[19:15].
  - Auto-decode maps opcode 1110011 with funct3[2]=1 to Z; funct3[2]=0 stays I.
- Undefined:
  - sel 6 behaves as NONE (output 0, o_sel=7).
  - Opcode 1110011 always decodes as I.

Test Plan:
- AUTO_DECODE=0, XLEN=32, ins=32'h12353112, i_ready=1, i_sel 0..4 on consecutive cycles -> outputs 0x00000123, 0x00000122, 0x00000122, 0x12353000, 0x00053922, each 1 cycle after acceptance, one per cycle.
- ins=32'hFFF00093, sel=0 -> 0xFFFFFFFF for XLEN=32 and 0xFFFFFFFFFFFFFFFF for XLEN=64; the same instruction with AUTO_DECODE=1 gives o_sel=0.
- AUTO_DECODE=1, ins=32'h12353112 sent 3 times -> o_illegal=1, o_dataout=0, o_illegal_cnt=3; with CNT_W=2 and 5 such sends -> o_illegal_cnt holds at 3.
- Backpressure: i_ready=0 while streaming A, B, C -> o_ready falls after B is accepted, C is held off, output stays A; raise i_ready -> A, B, C in order with no loss or duplication.
- Reset with FULL buffer -> after 1 edge o_valid=0, o_ready=1, o_illegal_cnt=0; B is never presented.
- IMM_GEN_ZIMM_EN defined, ins=32'h3401D073 (csrrwi, zimm=3) auto-decoded -> o_sel=6, o_dataout=3; macro undefined -> o_sel=0, o_dataout=0x00000340.
